mdu_sched: RTL and testbench

Sequencer for the pipeline's multiply/divide resource. It sits in stage E beside the ALU and accepts one MDU operation per cycle from the E-stage control word. It owns the HI/LO architectural registers and times multi-cycle MULT/DIV operations, driving `busy` so the hazard logic can stall MDU-dependent instructions in D. It commits results atomically on completion and supports abort of an in-flight operation for exception flushes.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_sched_if.sv | 24 ++
 rtl/mdu_arith.sv | 64 ++++++
 rtl/mdu_sched.sv | 132 +++++++++++++
 tb/tb_mdu_sched.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, default
// latencies, FSM state encoding and small op-class decoders.
package mdu_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MFHI  = 3'd6;
   localparam logic [2:0] OP_MFLO  = 3'd7;

   localparam int MUL_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Op codes 0..3 are the multi-cycle MULT/MULTU/DIV/DIVU group.
   function automatic logic is_mdu_op(input logic [2:0] op);
      return ~op[2];
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// E-stage control/data bundle between the pipeline and the MDU sequencer.
interface mdu_sched_if;

   logic        start;
   logic        we;
   logic        cancel;
   logic [2:0]  sel;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] c;

   modport master (
      output start, we, cancel, sel, a, b,
      input  busy, done, c
   );

   modport slave (
      input  start, we, cancel, sel, a, b,
      output busy, done, c
   );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for any
// MULT/MULTU/DIV/DIVU op and flags a zero divisor so the sequencer can skip
// the commit.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [2:0]  sel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero
);

   logic        is_div;
   logic        is_signed;
   logic        neg_a;
   logic        neg_b;
   logic [63:0] prod;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] quo_mag;
   logic [31:0] rem_mag;

   assign is_div    = is_div_op(sel);
   assign is_signed = (sel == OP_MULT) || (sel == OP_DIV);
   assign div_zero  = is_div && (b == 32'd0);

   // Signed ops work on magnitudes; signs are reapplied after the unsigned core.
   always_comb begin
      // NOTE: every output of a combinational block gets a value before any
      // branch, so no path can leave it holding state and infer a latch.
      hi      = 32'd0;
      lo      = 32'd0;
      neg_a   = is_signed & a[31];
      neg_b   = is_signed & b[31];
      mag_a   = neg_a ? (~a + 32'd1) : a;
      mag_b   = neg_b ? (~b + 32'd1) : b;
      // A zero divisor is swapped for 1 only to keep the divider well defined;
      // the result is discarded at commit.
      divisor = div_zero ? 32'd1 : mag_b;
      quo_mag = mag_a / divisor;
      rem_mag = mag_a % divisor;
      prod    = is_signed ? ({{32{a[31]}}, a} * {{32{b[31]}}, b})
                          : ({32'd0, a} * {32'd0, b});

      if (is_div) begin
         if (is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            // Most-negative / -1 overflows; architecturally LO wraps, HI is 0.
            lo = 32'h8000_0000;
            hi = 32'd0;
         end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            lo = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
            hi = neg_a ? (~rem_mag + 32'd1) : rem_mag;
         end
      end else begin
         hi = prod[63:32];
         lo = prod[31:0];
      end
   end

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide sequencer for stage E. Holds the architectural HI/LO pair,
// captures a result at launch, counts out the op latency with `busy` high,
// and commits atomically in the final cycle unless cancelled.
module mdu_sched
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   mdu_sched_if.slave  bus
);

   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
   localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] pend_hi_q;
   logic [31:0] pend_lo_q;
   logic        pend_dz_q;

   logic        launch;
   logic        commit;
   logic        wr_hi;
   logic        wr_lo;

   logic [31:0] arith_hi;
   logic [31:0] arith_lo;
   logic        arith_dz;

   mdu_arith u_arith (
      .sel      (bus.sel),
      .a        (bus.a),
      .b        (bus.b),
      .hi       (arith_hi),
      .lo       (arith_lo),
      .div_zero (arith_dz)
   );

   // FSM state and latency counter register.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and write-strobe decode; cancel outranks completion.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      launch  = 1'b0;
      commit  = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && is_mdu_op(bus.sel)) begin
               launch  = 1'b1;
               state_d = ST_RUN;
               cnt_d   = is_div_op(bus.sel) ? DIV_LOAD : MUL_LOAD;
            end else if (bus.we) begin
               wr_hi = (bus.sel == OP_MTHI);
               wr_lo = (bus.sel == OP_MTLO);
            end
         end
         ST_RUN: begin
            if (bus.cancel) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Result is captured at launch so forwarded operands may change during RUN.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: these capture registers are reset even though they are only read
      // after a launch, so a mid-op reset leaves no stale pending result.
      if (!rst) begin
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_dz_q <= 1'b0;
      end else if (launch) begin
         pend_hi_q <= arith_hi;
         pend_lo_q <= arith_lo;
         pend_dz_q <= arith_dz;
      end
   end

   // Architectural HI/LO: atomic commit at completion, or MTHI/MTLO in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (commit) begin
         if (!pend_dz_q) begin
            hi_q <= pend_hi_q;
            lo_q <= pend_lo_q;
         end
      end else begin
         if (wr_hi) hi_q <= bus.a;
         if (wr_lo) lo_q <= bus.a;
      end
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_RUN) && (cnt_q == 4'd1) && !bus.cancel;
   assign bus.c    = (bus.sel == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: latency/done timing, multiply and divide
// results, divide special cases, MTHI, cancel, back-to-back ops and reset.
module tb_mdu_sched;
   import mdu_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mdu_sched_if bus ();

   mdu_sched #(
      .MUL_CYCLES (5),
      .DIV_CYCLES (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance into the next cycle, sampling point 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [2:0] op);
      bus.sel = op;
      #1;
   endtask

   // Launch an op, check busy/done/old LO across its N cycles, then the commit.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [31:0] av, input logic [31:0] bv, input int n,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic [31:0] old_lo);
      bus.sel   = op;
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      peek(OP_MFLO);
      for (int k = 1; k <= n; k++) begin
         check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         check({tag, "_done"}, 32'(bus.done), (k == n) ? 32'd1 : 32'd0);
         check({tag, "_old_lo"}, bus.c, old_lo);
         step();
      end
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      check({tag, "_lo"}, bus.c, elo);
      peek(OP_MFHI);
      check({tag, "_hi"}, bus.c, ehi);
      peek(OP_MFLO);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst        = 1'b0;
      bus.start  = 1'b0;
      bus.we     = 1'b0;
      bus.cancel = 1'b0;
      bus.sel    = OP_MFLO;
      bus.a      = 32'd0;
      bus.b      = 32'd0;

      // Reset state.
      step();
      step();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_lo", bus.c, 32'd0);
      peek(OP_MFHI);
      check("rst_hi", bus.c, 32'd0);
      rst = 1'b1;
      step();

      // Multiply signed/unsigned, divide signed/unsigned.
      run_op("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd2, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5,  32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
      run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
      run_op("divu",  OP_DIVU,  32'd7,         32'd2, 10, 32'd1,         32'd3,         32'hFFFF_FFFD);

      // MTHI then divide by zero leaves HI/LO untouched.
      bus.sel = OP_MTHI;
      bus.a   = 32'h1234_5678;
      bus.we  = 1'b1;
      step();
      bus.we = 1'b0;
      peek(OP_MFHI);
      check("mthi_read", bus.c, 32'h1234_5678);
      run_op("div0", OP_DIV, 32'h0000_AAAA, 32'd0, 10, 32'h1234_5678, 32'd3, 32'd3);

      // Signed overflow case.
      run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 32'd3);

      // start with a non-MDU op code is ignored.
      bus.sel   = OP_MTLO;
      bus.a     = 32'h55;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      peek(OP_MFLO);
      check("start_sel4_busy", 32'(bus.busy), 32'd0);
      check("start_sel4_lo", bus.c, 32'h8000_0000);

      // Cancel in cycle 3 of a MULT.
      bus.sel   = OP_MULT;
      bus.a     = 32'd3;
      bus.b     = 32'd4;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      peek(OP_MFLO);
      check("cancel_c1_busy", 32'(bus.busy), 32'd1);
      step();
      step();
      bus.cancel = 1'b1;
      #1;
      check("cancel_c3_busy", 32'(bus.busy), 32'd1);
      check("cancel_c3_done", 32'(bus.done), 32'd0);
      step();
      bus.cancel = 1'b0;
      check("cancel_c4_busy", 32'(bus.busy), 32'd0);
      check("cancel_c4_lo", bus.c, 32'h8000_0000);
      peek(OP_MFHI);
      check("cancel_c4_hi", bus.c, 32'd0);

      // Start in cycle 4 after cancel, then a zero-gap DIVU.
      run_op("b2b_mulu", OP_MULTU, 32'd5,   32'd6, 5,  32'd0, 32'd30, 32'h8000_0000);
      run_op("b2b_divu", OP_DIVU,  32'd100, 32'd7, 10, 32'd2, 32'd14, 32'd30);

      // Cancel coinciding with the final cycle suppresses done and commit.
      bus.sel   = OP_MULT;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      peek(OP_MFLO);
      step();
      step();
      step();
      step();
      bus.cancel = 1'b1;
      #1;
      check("lastcan_busy", 32'(bus.busy), 32'd1);
      check("lastcan_done", 32'(bus.done), 32'd0);
      step();
      bus.cancel = 1'b0;
      check("lastcan_idle", 32'(bus.busy), 32'd0);
      check("lastcan_lo", bus.c, 32'd14);
      peek(OP_MFHI);
      check("lastcan_hi", bus.c, 32'd2);

      // Reset asserted in cycle 4 of a DIVU clears everything at once.
      bus.sel   = OP_DIVU;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      rst = 1'b0;
      peek(OP_MFLO);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_lo", bus.c, 32'd0);
      peek(OP_MFHI);
      check("midrst_hi", bus.c, 32'd0);
      step();
      rst = 1'b1;
      step();

      // start and we during RUN are ignored.
      bus.sel   = OP_MULTU;
      bus.a     = 32'd3;
      bus.b     = 32'd4;
      bus.start = 1'b1;
      step();
      step();
      bus.sel = OP_DIVU;
      bus.a   = 32'd9;
      bus.b   = 32'd3;
      step();
      bus.start = 1'b0;
      bus.we    = 1'b1;
      bus.sel   = OP_MTLO;
      bus.a     = 32'h0000_DEAD;
      step();
      bus.we = 1'b0;
      peek(OP_MFLO);
      check("runign_c4_busy", 32'(bus.busy), 32'd1);
      check("runign_c4_lo", bus.c, 32'd0);
      step();
      check("runign_c5_done", 32'(bus.done), 32'd1);
      step();
      check("runign_idle", 32'(bus.busy), 32'd0);
      check("runign_lo", bus.c, 32'd12);
      peek(OP_MFHI);
      check("runign_hi", bus.c, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
